ifu_align: RTL and testbench

//  Instruction realignment buffer between fetch memory response and ifu_dec.

---
 rtl/ifu_pkg.sv | 11 +
 rtl/ifu_parcel_q.sv | 41 ++++
 rtl/ifu_align.sv | 66 ++++++
 tb/tb_ifu_align.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: parcel type and RVC length helper shared by the fetch alignment logic
package ifu_pkg;
  localparam int PARCEL_W = 16;
  typedef struct packed {
    logic [PARCEL_W-1:0] data;
    logic                err;
  } parcel_t;
  function automatic logic is_comp(input parcel_t p);
    return p.data[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/ifu_parcel_q.sv
// ifu_parcel_q: circular halfword FIFO, 0..2 pushes and 0..2 pops per cycle
module ifu_parcel_q
  import ifu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [1:0]             push_n,
  input  logic [1:0]             pop_n,
  input  parcel_t                push0,
  input  parcel_t                push1,
  output parcel_t                head,
  output parcel_t                head1,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  parcel_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head  = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_n != 2'd0) mem[wr_ptr] <= push0;
      if (push_n == 2'd2) mem[wr_ptr + AW'(1)] <= push1;
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
endmodule

// File: rtl/ifu_align.sv
// ifu_align: realigns 32-bit fetch words into whole RV32IC instructions with PC tracking
module ifu_align
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        fetch_err,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_comp,
  output logic        instr_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  parcel_t head, head1, push0, push1;
  logic [CW-1:0] count;
  logic [31:0] pc;
  logic [1:0] push_n, pop_n;
  logic drop_low, push, pop, comp;
  assign comp        = is_comp(head);
  assign fetch_ready = !flush && (CW'(DEPTH) - count >= CW'(2));
  assign instr_valid = !flush && ((count >= CW'(1) && comp) || count >= CW'(2));
  assign push        = fetch_valid && fetch_ready;
  assign pop         = instr_valid && instr_ready;
  assign push_n      = push ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n       = pop ? (comp ? 2'd1 : 2'd2) : 2'd0;
  // With drop_low the upper halfword becomes the first written parcel
  assign push0       = {drop_low ? fetch_data[31:16] : fetch_data[15:0], fetch_err};
  assign push1       = {fetch_data[31:16], fetch_err};
  assign instr       = !instr_valid ? '0 : comp ? {16'h0, head.data} : {head1.data, head.data};
  assign instr_comp  = instr_valid && comp;
  assign instr_err   = instr_valid && (head.err || (!comp && head1.err));
  assign instr_pc    = pc;
  ifu_parcel_q #(.DEPTH(DEPTH)) u_q (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .push_n (push_n),
    .pop_n  (pop_n),
    .push0  (push0),
    .push1  (push1),
    .head   (head),
    .head1  (head1),
    .count  (count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_low <= RESET_PC[1];
    end else if (flush) begin
      pc       <= flush_pc & ~32'd1;
      drop_low <= flush_pc[1];
    end else begin
      if (pop) pc <= pc + (comp ? 32'd2 : 32'd4);
      if (push) drop_low <= 1'b0;
    end
endmodule

// File: tb/tb_ifu_align.sv
// tb_ifu_align: randomized scoreboard bench with a parcel-stream reference decoder
module tb_ifu_align;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  logic clk, rst_n, fetch_valid, fetch_ready, fetch_err, flush;
  logic instr_valid, instr_ready, instr_comp, instr_err;
  logic [31:0] fetch_data, flush_pc, instr, instr_pc;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  logic [16:0] pend[$];
  logic [31:0] mpc, dpc;
  logic mdrop;
  int mcount;
  int checks = 0;
  int errors = 0;
  ifu_align #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_comp  (instr_comp),
    .instr_err   (instr_err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic model_clear(input logic [31:0] p);
    exp_q.delete();
    pend.delete();
    mcount = 0;
    mpc = p & ~32'd1;
    dpc = p & ~32'd1;
    mdrop = p[1];
  endtask
  // Turn queued halfwords into whole instructions as soon as each is complete
  task automatic decode();
    exp_t e;
    while (pend.size() != 0) begin
      if (pend[0][1:0] != 2'b11) begin
        e = '{instr: {16'h0, pend[0][15:0]}, pc: dpc, comp: 1'b1, err: pend[0][16]};
        void'(pend.pop_front());
        dpc += 2;
      end else if (pend.size() >= 2) begin
        e = '{instr: {pend[1][15:0], pend[0][15:0]}, pc: dpc, comp: 1'b0, err: pend[0][16] | pend[1][16]};
        void'(pend.pop_front());
        void'(pend.pop_front());
        dpc += 4;
      end else break;
      exp_q.push_back(e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) model_clear(RESET_PC);
    else if (flush) begin
      chk("flush_instr_valid", instr_valid, 0);
      chk("flush_fetch_ready", fetch_ready, 0);
      model_clear(flush_pc);
    end else begin
      chk("fetch_ready", fetch_ready, (DEPTH - mcount) >= 2);
      chk("instr_valid", instr_valid, exp_q.size() != 0);
      chk("instr_pc", instr_pc, mpc);
      if (instr_valid && exp_q.size() != 0) begin
        chk("instr", instr, exp_q[0].instr);
        chk("instr_comp", instr_comp, exp_q[0].comp);
        chk("instr_err", instr_err, exp_q[0].err);
        chk("exp_pc", instr_pc, exp_q[0].pc);
        if (instr_ready) begin
          mcount -= exp_q[0].comp ? 1 : 2;
          mpc += exp_q[0].comp ? 32'd2 : 32'd4;
          void'(exp_q.pop_front());
        end
      end
      if (fetch_valid && fetch_ready) begin
        if (!mdrop) pend.push_back({fetch_err, fetch_data[15:0]});
        pend.push_back({fetch_err, fetch_data[31:16]});
        mcount += mdrop ? 1 : 2;
        mdrop = 1'b0;
        decode();
      end
    end
  end
  task automatic step(input logic fv, input logic [31:0] fd, input logic fe, input logic rdy,
                      input logic fl = 1'b0, input logic [31:0] fp = 32'h0);
    fetch_valid = fv;
    fetch_data  = fd;
    fetch_err   = fe;
    instr_ready = rdy;
    flush       = fl;
    flush_pc    = fp;
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset();
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, RESET_PC);
    chk("rst_instr_comp", instr_comp, 0);
    chk("rst_instr_err", instr_err, 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    #2;
    check_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1;
    step(0, 0, 0, 0);
    check_reset();
  endtask
  initial begin
    fetch_valid = 0;
    fetch_data  = 0;
    fetch_err   = 0;
    flush       = 0;
    flush_pc    = 0;
    instr_ready = 0;
    rst_n       = 1;
    #1;
    do_reset();
    step(1, 32'h00A00093, 0, 0);
    step(0, 0, 0, 1);
    step(1, 32'h45014501, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 32'h00934501, 0, 1);
    step(0, 0, 0, 1);
    step(1, 32'h458500A0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 32'h45014501, 0, 0);
    step(1, 32'h45014501, 0, 1, 1, 32'h8000_0102);
    step(1, 32'h45854501, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 32'h45014585 + i, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    step(1, 32'h00934501, 0, 1);
    step(1, 32'h458500A0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      fl = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0, fl, $urandom);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    chk("drain_empty", exp_q.size(), 0);
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
    do_reset();
    step(1, 32'h00A00093, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("final_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
